controller_fsm_v2: RTL and testbench
====================================

Name: controller_fsm_v2

Overview:
- Parametrised second-generation control unit for the SimpleCPU datapath.
- Sequences fetch/decode/execute for an extended six-instruction set: LOAD, STORE, ADD, LOADCONST, SUB, JMPZ, plus HALT.
- Adds ready/wait handshakes to instruction and data memory, a PC-load path for branches, and sticky halt/error states.
- Sits between instruction register, program counter, data memory and register file/ALU datapath.

Parameters:
- IW, 16, instruction width.
- OPW, 4, opcode width; opcode = instruction[IW-1 -: OPW].
- RAW, 4, register-file address width.
- DAW, 8, data-memory address / constant / branch-offset width.
- Legality: IW >= OPW+3*RAW and IW >= OPW+RAW+DAW; violation is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- instruction  in  IW  IR contents.
- I_ready  in  1  instruction memory data valid.
- D_ready  in  1  data memory access complete.
- RF_Rp_zero  in  1  Rp read port value == 0.
- PC_clr  out  1  clear PC.
- PC_inc  out  1  increment PC.
- PC_ld  out  1  load PC <= PC + sign-extended PC_offset.
- PC_offset  out  DAW  branch offset.
- I_rd  out  1  instruction memory read request.
- IR_ld  out  1  IR load enable.
- D_addr  out  DAW  data memory address.
- D_rd  out  1  data memory read.
- D_wr  out  1  data memory write.
- RF_s  out  2  write-data mux select: 0=ALU, 1=memory, 2=RF_W_data.
- RF_W_data  out  DAW  constant for LOADCONST.
- RF_W_addr  out  RAW  write address.
- RF_W_wr  out  1  write enable.
- RF_Rp_addr  out  RAW  Rp read address.
- RF_Rp_rd  out  1  Rp read enable.
- RF_Rq_addr  out  RAW  Rq read address.
- RF_Rq_rd  out  1  Rq read enable.
- alu_s  out  2  0=pass-through, 1=add, 2=sub.
- halted  out  1  HALT reached.
- error  out  1  illegal opcode seen.

Behaviour:
- Fields:
  - ra = instruction[IW-OPW-1 -: RAW]
  - rb = instruction[2*RAW-1:RAW]
  - rc = instruction[RAW-1:0]
  - d / c / offset = instruction[DAW-1:0]
- All outputs are driven to 0 unless listed for the current state; no X outputs.
- States: INIT, FETCH, DECODE, LOAD, STORE, ADD, LOADC, SUB, JMPZ, JMPT, HALT, ERROR.
- rst low: state = INIT immediately (asynchronous), regardless of current state, including mid memory wait.
  - Output values during and after reset: PC_clr=1, all other outputs 0.
- INIT: PC_clr=1 -> FETCH.
- FETCH:
  - I_rd=1.
  - IR_ld = PC_inc = I_ready.
  - Stays in FETCH while !I_ready; -> DECODE on I_ready.
  - PC increments exactly once per instruction.
- DECODE: outputs 0. Next state by opcode:
  - 0 -> LOAD
  - 1 -> STORE
  - 2 -> ADD
  - 3 -> LOADC
  - 4 -> SUB
  - 5 -> JMPZ
  - all-ones -> HALT
  - else -> ERROR
- LOAD:
  - D_addr=d, D_rd=1, RF_s=1, RF_W_addr=ra.
  - RF_W_wr = D_ready.
  - Holds until D_ready, then -> FETCH.
- STORE:
  - D_addr=d, D_wr=1, RF_Rp_addr=ra, RF_Rp_rd=1.
  - Holds until D_ready, then -> FETCH.
- ADD and SUB (single cycle):
  - RF_Rp_addr=rb, RF_Rq_addr=rc, both rd=1.
  - RF_s=0, RF_W_addr=ra, RF_W_wr=1.
  - alu_s=1 for ADD, 2 for SUB.
  - -> FETCH.
- LOADC (single cycle): RF_s=2, RF_W_data=c, RF_W_addr=ra, RF_W_wr=1 -> FETCH.
- JMPZ: RF_Rp_addr=ra, RF_Rp_rd=1.
  - RF_Rp_zero=1 -> JMPT.
  - RF_Rp_zero=0 -> FETCH.
- JMPT:
  - PC_ld=1, PC_offset=offset -> FETCH.
  - Offset is relative to the already-incremented PC.
- HALT: halted=1; stays in HALT until reset.
- ERROR: error=1; stays in ERROR until reset.
- Latency, excluding memory wait cycles:
  - 3 cycles for ADD/SUB/LOADC/LOAD/STORE.
  - 3 cycles for JMPZ not taken.
  - 4 cycles for JMPZ taken.
- Mutual exclusion:
  - PC_clr, PC_inc and PC_ld are never asserted together.
  - D_rd and D_wr are never asserted together.
- Illegal parameters are rejected at elaboration.

Test Plan:
- Reset: hold rst=0 three cycles, release -> PC_clr=1 for one cycle, FETCH next cycle with I_rd=1; pull rst=0 during a LOAD wait -> INIT on the same edge window, D_rd=0 immediately.
- Fetch wait: I_ready=0 for 3 cycles then 1, instruction=16'h2312 -> exactly one PC_inc/IR_ld pulse. ADD state then drives RF_W_addr=3, RF_Rp_addr=1, RF_Rq_addr=2, alu_s=1, RF_W_wr=1.
- LOAD 16'h0A2C with D_ready delayed 2 cycles -> D_addr=8'h2C, D_rd=1 for 3 cycles; RF_W_wr=1 only in the D_ready cycle, RF_W_addr=10, RF_s=1.
- LOADC 16'h3455 -> RF_s=2, RF_W_data=8'h55, RF_W_addr=4; SUB 16'h4123 -> alu_s=2.
- JMPZ 16'h51FE: with RF_Rp_zero=1 -> PC_ld=1 with PC_offset=8'hFE, total 4 cycles; with RF_Rp_zero=0 -> no PC_ld, back to FETCH after 3 cycles.
- Opcode 4'hF -> halted=1 held for 20 cycles, no I_rd; opcode 4'h9 -> error=1 held for 20 cycles; both clear only on rst=0.

Source files
------------

// File: rtl/controller_fsm_v2.sv
// SimpleCPU second-generation control unit: fetch/decode/execute sequencing with
// instruction/data memory handshakes, relative branches and sticky HALT/ERROR.
module controller_fsm_v2 #(
  parameter int IW  = 16,
  parameter int OPW = 4,
  parameter int RAW = 4,
  parameter int DAW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IW-1:0]  instruction,
  input  logic           I_ready,
  input  logic           D_ready,
  input  logic           RF_Rp_zero,
  output logic           PC_clr,
  output logic           PC_inc,
  output logic           PC_ld,
  output logic [DAW-1:0] PC_offset,
  output logic           I_rd,
  output logic           IR_ld,
  output logic [DAW-1:0] D_addr,
  output logic           D_rd,
  output logic           D_wr,
  output logic [1:0]     RF_s,
  output logic [DAW-1:0] RF_W_data,
  output logic [RAW-1:0] RF_W_addr,
  output logic           RF_W_wr,
  output logic [RAW-1:0] RF_Rp_addr,
  output logic           RF_Rp_rd,
  output logic [RAW-1:0] RF_Rq_addr,
  output logic           RF_Rq_rd,
  output logic [1:0]     alu_s,
  output logic           halted,
  output logic           error
);

  if (IW < OPW + 3*RAW || IW < OPW + RAW + DAW) begin : g_bad_params
    $error("controller_fsm_v2: instruction too narrow for its fields");
  end

  typedef enum logic [3:0] {
    INIT, FETCH, DECODE, LOAD, STORE, ADD, LOADC, SUB, JMPZ, JMPT, HALT, ERROR
  } state_t;

  typedef struct packed {
    logic           pc_clr;
    logic           pc_ld;
    logic           i_rd;
    logic           d_rd;
    logic           d_wr;
    logic           w_wr;
    logic           rp_rd;
    logic           rq_rd;
    logic           halted;
    logic           error;
    logic [1:0]     rf_s;
    logic [1:0]     alu_s;
    logic [DAW-1:0] pc_offset;
    logic [DAW-1:0] d_addr;
    logic [DAW-1:0] w_data;
    logic [RAW-1:0] w_addr;
    logic [RAW-1:0] rp_addr;
    logic [RAW-1:0] rq_addr;
  } ctl_t;

  localparam logic [OPW-1:0] OP_LOAD  = OPW'(0);
  localparam logic [OPW-1:0] OP_STORE = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(2);
  localparam logic [OPW-1:0] OP_LOADC = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_JMPZ  = OPW'(5);
  localparam logic [OPW-1:0] OP_HALT  = {OPW{1'b1}};

  logic [OPW-1:0] opcode;
  logic [RAW-1:0] ra, rb, rc;
  logic [DAW-1:0] imm;

  assign opcode = instruction[IW-1 -: OPW];
  assign ra     = instruction[IW-OPW-1 -: RAW];
  assign rb     = instruction[2*RAW-1:RAW];
  assign rc     = instruction[RAW-1:0];
  assign imm    = instruction[DAW-1:0];

  state_t state, state_n;
  ctl_t   ctl, ctl_n;

  // Next state, plus the outputs of that next state so they can be registered.
  always_comb begin
    state_n = state;
    case (state)
      INIT:   state_n = FETCH;
      FETCH:  if (I_ready) state_n = DECODE;
      DECODE: begin
        case (opcode)
          OP_LOAD:  state_n = LOAD;
          OP_STORE: state_n = STORE;
          OP_ADD:   state_n = ADD;
          OP_LOADC: state_n = LOADC;
          OP_SUB:   state_n = SUB;
          OP_JMPZ:  state_n = JMPZ;
          OP_HALT:  state_n = HALT;
          default:  state_n = ERROR;
        endcase
      end
      LOAD, STORE:           if (D_ready) state_n = FETCH;
      ADD, SUB, LOADC, JMPT: state_n = FETCH;
      JMPZ:                  state_n = RF_Rp_zero ? JMPT : FETCH;
      HALT:                  state_n = HALT;
      ERROR:                 state_n = ERROR;
      default:               state_n = ERROR;
    endcase

    ctl_n = '0;
    case (state_n)
      INIT:  ctl_n.pc_clr = 1'b1;
      FETCH: ctl_n.i_rd   = 1'b1;
      LOAD: begin
        ctl_n.d_addr = imm;
        ctl_n.d_rd   = 1'b1;
        ctl_n.rf_s   = 2'd1;
        ctl_n.w_addr = ra;
      end
      STORE: begin
        ctl_n.d_addr  = imm;
        ctl_n.d_wr    = 1'b1;
        ctl_n.rp_addr = ra;
        ctl_n.rp_rd   = 1'b1;
      end
      ADD, SUB: begin
        ctl_n.rp_addr = rb;
        ctl_n.rq_addr = rc;
        ctl_n.rp_rd   = 1'b1;
        ctl_n.rq_rd   = 1'b1;
        ctl_n.w_addr  = ra;
        ctl_n.w_wr    = 1'b1;
        ctl_n.alu_s   = (state_n == SUB) ? 2'd2 : 2'd1;
      end
      LOADC: begin
        ctl_n.rf_s   = 2'd2;
        ctl_n.w_data = imm;
        ctl_n.w_addr = ra;
        ctl_n.w_wr   = 1'b1;
      end
      JMPZ: begin
        ctl_n.rp_addr = ra;
        ctl_n.rp_rd   = 1'b1;
      end
      JMPT: begin
        ctl_n.pc_ld     = 1'b1;
        ctl_n.pc_offset = imm;
      end
      HALT:    ctl_n.halted = 1'b1;
      ERROR:   ctl_n.error  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= INIT;
      ctl        <= '0;
      ctl.pc_clr <= 1'b1;
    end else begin
      state <= state_n;
      ctl   <= ctl_n;
    end
  end

  // Handshake-qualified strobes must follow the ready inputs in the same cycle.
  assign PC_inc     = ctl.i_rd & I_ready;
  assign IR_ld      = ctl.i_rd & I_ready;
  assign RF_W_wr    = ctl.w_wr | (ctl.d_rd & D_ready);

  assign PC_clr     = ctl.pc_clr;
  assign PC_ld      = ctl.pc_ld;
  assign PC_offset  = ctl.pc_offset;
  assign I_rd       = ctl.i_rd;
  assign D_addr     = ctl.d_addr;
  assign D_rd       = ctl.d_rd;
  assign D_wr       = ctl.d_wr;
  assign RF_s       = ctl.rf_s;
  assign RF_W_data  = ctl.w_data;
  assign RF_W_addr  = ctl.w_addr;
  assign RF_Rp_addr = ctl.rp_addr;
  assign RF_Rp_rd   = ctl.rp_rd;
  assign RF_Rq_addr = ctl.rq_addr;
  assign RF_Rq_rd   = ctl.rq_rd;
  assign alu_s      = ctl.alu_s;
  assign halted     = ctl.halted;
  assign error      = ctl.error;

endmodule

// File: tb/tb_controller_fsm_v2.sv
// Bench for controller_fsm_v2: directed instruction sequences push per-cycle
// expected outputs; a negedge monitor pops and compares them.
module tb_controller_fsm_v2;

  logic        clk, rst;
  logic [15:0] instruction;
  logic        I_ready, D_ready, RF_Rp_zero;
  logic        PC_clr, PC_inc, PC_ld, I_rd, IR_ld, D_rd, D_wr, RF_W_wr;
  logic        RF_Rp_rd, RF_Rq_rd, halted, error;
  logic [7:0]  PC_offset, D_addr, RF_W_data;
  logic [3:0]  RF_W_addr, RF_Rp_addr, RF_Rq_addr;
  logic [1:0]  RF_s, alu_s;

  controller_fsm_v2 #(.IW(16), .OPW(4), .RAW(4), .DAW(8)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .I_ready(I_ready),
    .D_ready(D_ready), .RF_Rp_zero(RF_Rp_zero), .PC_clr(PC_clr), .PC_inc(PC_inc),
    .PC_ld(PC_ld), .PC_offset(PC_offset), .I_rd(I_rd), .IR_ld(IR_ld),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .RF_s(RF_s), .RF_W_data(RF_W_data),
    .RF_W_addr(RF_W_addr), .RF_W_wr(RF_W_wr), .RF_Rp_addr(RF_Rp_addr),
    .RF_Rp_rd(RF_Rp_rd), .RF_Rq_addr(RF_Rq_addr), .RF_Rq_rd(RF_Rq_rd),
    .alu_s(alu_s), .halted(halted), .error(error)
  );

  typedef struct packed {
    logic       pc_clr, pc_inc, pc_ld;
    logic [7:0] pc_off;
    logic       i_rd, ir_ld;
    logic [7:0] d_addr;
    logic       d_rd, d_wr;
    logic [1:0] rf_s;
    logic [7:0] w_data;
    logic [3:0] w_addr;
    logic       w_wr;
    logic [3:0] rp_addr;
    logic       rp_rd;
    logic [3:0] rq_addr;
    logic       rq_rd;
    logic [1:0] alu_s;
    logic       halted, error;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    obs_t e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {PC_clr, PC_inc, PC_ld, PC_offset, I_rd, IR_ld, D_addr, D_rd, D_wr,
            RF_s, RF_W_data, RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd,
            RF_Rq_addr, RF_Rq_rd, alu_s, halted, error};
      checks++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s @%0t: got %h required %h", nm, $time, a, e);
      end
    end
  end

  // Push the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t o_clr();
    obs_t e = '0;
    e.pc_clr = 1'b1;
    return e;
  endfunction

  function automatic obs_t o_fetch(input logic rdy);
    obs_t e = '0;
    e.i_rd   = 1'b1;
    e.ir_ld  = rdy;
    e.pc_inc = rdy;
    return e;
  endfunction

  // Fetch with nwait stalled cycles, then decode; I_ready stays high afterward.
  task automatic run_fetch(input logic [15:0] instr, input int nwait);
    instruction = instr;
    I_ready = 1'b0;
    repeat (nwait) cyc("fetch_wait", o_fetch(1'b0));
    I_ready = 1'b1;
    cyc("fetch", o_fetch(1'b1));
    cyc("decode", '0);
  endtask

  initial begin
    obs_t e;
    rst = 1'b1; instruction = '0; I_ready = 1'b0; D_ready = 1'b0; RF_Rp_zero = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;

    repeat (3) cyc("reset_hold", o_clr());
    rst = 1'b1;
    cyc("init", o_clr());

    // ADD r3 = r1 + r2, three fetch stall cycles
    run_fetch(16'h2312, 3);
    e = '0; e.rp_addr = 4'd1; e.rq_addr = 4'd2; e.rp_rd = 1'b1; e.rq_rd = 1'b1;
    e.w_addr = 4'd3; e.w_wr = 1'b1; e.alu_s = 2'd1;
    cyc("add", e);

    // LOADC r4 = 0x55
    run_fetch(16'h3455, 0);
    e = '0; e.rf_s = 2'd2; e.w_data = 8'h55; e.w_addr = 4'd4; e.w_wr = 1'b1;
    cyc("loadc", e);

    // SUB r1 = r2 - r3
    run_fetch(16'h4123, 0);
    e = '0; e.rp_addr = 4'd2; e.rq_addr = 4'd3; e.rp_rd = 1'b1; e.rq_rd = 1'b1;
    e.w_addr = 4'd1; e.w_wr = 1'b1; e.alu_s = 2'd2;
    cyc("sub", e);

    // LOAD r10 = M[0x2C], data ready on the third cycle
    run_fetch(16'h0A2C, 1);
    D_ready = 1'b0;
    e = '0; e.d_addr = 8'h2C; e.d_rd = 1'b1; e.rf_s = 2'd1; e.w_addr = 4'd10;
    cyc("load_wait", e);
    cyc("load_wait", e);
    D_ready = 1'b1;
    e.w_wr = 1'b1;
    cyc("load_done", e);

    // STORE M[0x33] = r5; D_ready left high into fetch to check it is ignored
    run_fetch(16'h1533, 0);
    D_ready = 1'b0;
    e = '0; e.d_addr = 8'h33; e.d_wr = 1'b1; e.rp_addr = 4'd5; e.rp_rd = 1'b1;
    cyc("store_wait", e);
    D_ready = 1'b1;
    cyc("store_done", e);

    // JMPZ taken
    run_fetch(16'h51FE, 0);
    D_ready = 1'b0;
    RF_Rp_zero = 1'b1;
    e = '0; e.rp_addr = 4'd1; e.rp_rd = 1'b1;
    cyc("jmpz_taken", e);
    e = '0; e.pc_ld = 1'b1; e.pc_off = 8'hFE;
    cyc("jmpt", e);
    RF_Rp_zero = 1'b0;

    // JMPZ not taken: the following fetch must come straight after
    run_fetch(16'h51FE, 0);
    e = '0; e.rp_addr = 4'd1; e.rp_rd = 1'b1;
    cyc("jmpz_not_taken", e);

    // Reset asserted in the middle of a LOAD wait
    run_fetch(16'h0A2C, 0);
    e = '0; e.d_addr = 8'h2C; e.d_rd = 1'b1; e.rf_s = 2'd1; e.w_addr = 4'd10;
    cyc("load_wait2", e);
    rst = 1'b0;
    cyc("reset_mid_load", o_clr());
    rst = 1'b1;
    cyc("init2", o_clr());

    // HALT is sticky until reset
    run_fetch(16'hF000, 0);
    e = '0; e.halted = 1'b1;
    repeat (20) cyc("halt", e);
    rst = 1'b0;
    cyc("reset_halt", o_clr());
    rst = 1'b1;
    cyc("init3", o_clr());

    // Illegal opcode is sticky until reset
    run_fetch(16'h9000, 0);
    e = '0; e.error = 1'b1;
    repeat (20) cyc("error", e);
    rst = 1'b0;
    cyc("reset_error", o_clr());
    rst = 1'b1;
    cyc("init4", o_clr());
    I_ready = 1'b0;
    cyc("fetch_after_error", o_fetch(1'b0));

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      fails++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
